// File: rtl/mem_sram_ctrl_pkg.sv
// Shared memory-bus types for the I/D arbiter and its downstream SRAM controller.
// Also holds small helpers used by the controller's acceptance logic.
package mem_sram_ctrl_pkg;

  typedef logic [31:0] Addr;
  typedef logic [31:0] UInt32;

  typedef struct packed {
    logic  valid;
    Addr   addr;
    logic  wen;
    UInt32 wdata;
  } MemBusReq;

  typedef struct packed {
    logic  valid;
    Addr   addr;
    UInt32 rdata;
  } MemBusResp;

  localparam int MEM_RD_LAT_MAX = 7;

  // Byte address is out of range when its word index reaches the SRAM depth.
  function automatic logic addr_out_of_range(input Addr a, input int unsigned words);
    return {2'b00, a[31:2]} >= words;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_sram_ctrl.sv
// Single-port synchronous SRAM controller behind the memory-bus arbiter.
// One request in flight; writes are silent, reads return one response pulse.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int    MEM_WORDS    = 4096,
  parameter int    READ_LATENCY = 1,
  parameter UInt32 ERR_RDATA    = 32'h0000_0000,
  localparam int   AW           = $clog2(MEM_WORDS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  MemBusReq        memreq,
  output logic            memreq_ready,
  output MemBusResp       memresp,
  output logic            sram_en,
  output logic            sram_we,
  output logic [AW-1:0]   sram_addr,
  output logic [31:0]     sram_wdata,
  input  logic [31:0]     sram_rdata,
  output logic [15:0]     err_cnt
);

  localparam int CNT_W = $clog2(MEM_RD_LAT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_READ_WAIT,
    S_RESP,
    S_ERR_RESP
  } state_e;

  state_e           state_q, state_d;
  Addr              addr_q, addr_d;
  UInt32            wdata_q, wdata_d;
  UInt32            rdata_q, rdata_d;
  Addr              resp_addr_q, resp_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_addr_q <= '0;
      cnt_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_addr_q <= resp_addr_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Response address/data live in their own registers so they hold while
  // later requests are latched.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    resp_addr_d = resp_addr_q;
    cnt_d       = cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (memreq.valid) begin
          addr_d  = memreq.addr;
          wdata_d = memreq.wdata;
          if (addr_out_of_range(memreq.addr, MEM_WORDS)) begin
            err_cnt_d = sat_inc16(err_cnt_q);
            if (!memreq.wen) begin
              state_d     = S_ERR_RESP;
              resp_addr_d = memreq.addr;
              rdata_d     = ERR_RDATA;
            end
          end else begin
            state_d = memreq.wen ? S_WRITE : S_READ;
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ: begin
        cnt_d   = CNT_W'(READ_LATENCY - 1);
        state_d = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d     = sram_rdata;
          resp_addr_d = addr_q;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:     state_d = S_IDLE;
      S_ERR_RESP: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    memreq_ready  = (state_q == S_IDLE);
    sram_en       = (state_q == S_WRITE) || (state_q == S_READ);
    sram_we       = (state_q == S_WRITE);
    sram_addr     = addr_q[2 +: AW];
    sram_wdata    = wdata_q;
    memresp.valid = (state_q == S_RESP) || (state_q == S_ERR_RESP);
    memresp.addr  = resp_addr_q;
    memresp.rdata = rdata_q;
    err_cnt       = err_cnt_q;
  end

endmodule
